// File: rtl/rdx_pkg.sv
// Shared types and constants for the radix pack/reorder stages.
package rdx_pkg;

  localparam int W_DATA   = 18;
  localparam int NLANE    = 5;
  localparam int FACT_MIN = 2;
  localparam int FACT_MAX = 5;

  typedef logic signed [W_DATA-1:0] smp_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

endpackage

// File: rtl/rdx_vec_cnt.sv
// Lane/vector counter pair with terminal-count flags and synchronous restart.
module rdx_vec_cnt #(
  parameter int wIdx = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            restart,
  input  logic            inc,
  input  logic [2:0]      lane_max,
  input  logic [wIdx-1:0] vec_max,
  output logic [2:0]      lane_cnt,
  output logic [wIdx-1:0] vec_cnt,
  output logic            lane_last,
  output logic            vec_last
);

  assign lane_last = (lane_cnt == lane_max);
  assign vec_last  = (vec_cnt == vec_max);

  // restart together with inc counts the restarting element as lane 0.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt <= '0;
      vec_cnt  <= '0;
    end else if (restart) begin
      lane_cnt <= inc ? 3'd1 : 3'd0;
      vec_cnt  <= '0;
    end else if (inc) begin
      if (lane_last) begin
        lane_cnt <= '0;
        vec_cnt  <= vec_last ? '0 : vec_cnt + 1'b1;
      end else begin
        lane_cnt <= lane_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/rdx_pack_twdl_idx.sv
// Packs a serial complex stream into factor-wide lane vectors and tags each
// vector with its twiddle numerator (vector index) and denominator (N).
module rdx_pack_twdl_idx
  import rdx_pkg::*;
#(
  parameter int wDataInOut = 18,
  parameter int wIdx       = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2:0]                   cfg_factor,
  input  logic [wIdx-1:0]              cfg_nvec,
  input  logic                         s_val,
  input  logic                         s_sop,
  input  logic signed [wDataInOut-1:0] s_real,
  input  logic signed [wDataInOut-1:0] s_imag,
  output logic                         out_val,
  output logic signed [wDataInOut-1:0] dout_real [0:NLANE-1],
  output logic signed [wDataInOut-1:0] dout_imag [0:NLANE-1],
  output logic [2:0]                   factor,
  output logic [wIdx-1:0]              twdl_numrtr_1,
  output logic [wIdx-1:0]              twdl_demontr,
  output logic                         eof,
  output logic                         err_abort,
  output logic                         err_drop
);

  state_t state, state_nxt;
  logic start, wr_fill, issue, drop, abort;

  logic [2:0]      factor_q;
  logic [wIdx-1:0] nvec_q, demontr_q, prod;
  logic [2:0]      lane_cnt;
  logic [wIdx-1:0] vec_cnt;
  logic            lane_last, vec_last;

  logic signed [wDataInOut-1:0] lane_real [0:NLANE-1];
  logic signed [wDataInOut-1:0] lane_imag [0:NLANE-1];

  // N fits in wIdx for legal configs, so the product is taken at wIdx bits.
  assign prod = wIdx'({{(wIdx-3){1'b0}}, cfg_factor} * cfg_nvec);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    wr_fill   = 1'b0;
    issue     = 1'b0;
    drop      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: if (s_val) begin
        if (s_sop) begin
          start     = 1'b1;
          state_nxt = FILL;
        end else begin
          drop = 1'b1;
        end
      end
      FILL: if (s_val) begin
        if (s_sop) begin
          start = 1'b1;
          abort = 1'b1;
        end else begin
          wr_fill = 1'b1;
          if (lane_last) begin
            issue = 1'b1;
            if (vec_last) state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  rdx_vec_cnt #(.wIdx(wIdx)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .restart   (start),
    .inc       (start | wr_fill),
    .lane_max  (factor_q - 3'd1),
    .vec_max   (nvec_q - wIdx'(1)),
    .lane_cnt  (lane_cnt),
    .vec_cnt   (vec_cnt),
    .lane_last (lane_last),
    .vec_last  (vec_last)
  );

  // NOTE: lane storage is deliberately not reset; each lane is written
  // within the current frame before it can reach an output.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NLANE; i++) begin
      if ((start && i == 0) || (wr_fill && lane_cnt == 3'(i))) begin
        lane_real[i] <= s_real;
        lane_imag[i] <= s_imag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      factor_q      <= '0;
      nvec_q        <= '0;
      demontr_q     <= '0;
      out_val       <= 1'b0;
      eof           <= 1'b0;
      twdl_numrtr_1 <= '0;
      twdl_demontr  <= '0;
      factor        <= '0;
      err_abort     <= 1'b0;
      err_drop      <= 1'b0;
      for (int i = 0; i < NLANE; i++) begin
        dout_real[i] <= '0;
        dout_imag[i] <= '0;
      end
    end else begin
      if (start) begin
        factor_q  <= cfg_factor;
        nvec_q    <= cfg_nvec;
        demontr_q <= prod;
      end
      out_val       <= issue;
      eof           <= issue & vec_last;
      twdl_numrtr_1 <= issue ? vec_cnt : '0;
      if (issue) begin
        twdl_demontr <= demontr_q;
        factor       <= factor_q;
      end
      // The completing sample bypasses lane storage straight to the output.
      for (int i = 0; i < NLANE; i++) begin
        if (issue && 3'(i) < factor_q) begin
          dout_real[i] <= (lane_cnt == 3'(i)) ? s_real : lane_real[i];
          dout_imag[i] <= (lane_cnt == 3'(i)) ? s_imag : lane_imag[i];
        end else begin
          dout_real[i] <= '0;
          dout_imag[i] <= '0;
        end
      end
      err_abort <= err_abort | abort;
      err_drop  <= err_drop | drop;
    end
  end

endmodule

// File: tb/tb_rdx_pack_twdl_idx.sv
// Directed self-checking bench for rdx_pack_twdl_idx.
module tb_rdx_pack_twdl_idx;
  import rdx_pkg::*;

  localparam int WI = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic [2:0]      cfg_factor;
  logic [WI-1:0]   cfg_nvec;
  logic            s_val, s_sop;
  smp_t            s_real, s_imag;
  logic            out_val, eof, err_abort, err_drop;
  smp_t            dout_real [0:NLANE-1];
  smp_t            dout_imag [0:NLANE-1];
  logic [2:0]      factor;
  logic [WI-1:0]   twdl_numrtr_1, twdl_demontr;

  int n_chk  = 0;
  int n_fail = 0;

  rdx_pack_twdl_idx #(.wDataInOut(W_DATA), .wIdx(WI)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_factor    (cfg_factor),
    .cfg_nvec      (cfg_nvec),
    .s_val         (s_val),
    .s_sop         (s_sop),
    .s_real        (s_real),
    .s_imag        (s_imag),
    .out_val       (out_val),
    .dout_real     (dout_real),
    .dout_imag     (dout_imag),
    .factor        (factor),
    .twdl_numrtr_1 (twdl_numrtr_1),
    .twdl_demontr  (twdl_demontr),
    .eof           (eof),
    .err_abort     (err_abort),
    .err_drop      (err_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock with the given input; out_val is checked #1 after the edge.
  task automatic drive(input bit v, input bit sop, input int val, input bit exp_ov);
    s_val  = v;
    s_sop  = sop;
    s_real = smp_t'(val);
    s_imag = smp_t'(-val);
    @(posedge clk); #1;
    check("out_val", int'(out_val), int'(exp_ov));
  endtask

  task automatic chk_vec(input int base, input int fac, input int k, input int n, input bit e);
    int ev;
    for (int i = 0; i < NLANE; i++) begin
      ev = (i < fac) ? base + i : 0;
      check($sformatf("k%0d_lane%0d_re", k, i), int'(dout_real[i]), ev);
      check($sformatf("k%0d_lane%0d_im", k, i), int'(dout_imag[i]), -ev);
    end
    check("numrtr", int'(twdl_numrtr_1), k);
    check("demontr", int'(twdl_demontr), n);
    check("factor", int'(factor), fac);
    check("eof", int'(eof), int'(e));
  endtask

  task automatic chk_quiet(input int n, input int fac);
    check("idle_lane0", int'(dout_real[0]), 0);
    check("idle_numrtr", int'(twdl_numrtr_1), 0);
    check("idle_eof", int'(eof), 0);
    check("idle_demontr_hold", int'(twdl_demontr), n);
    check("idle_factor_hold", int'(factor), fac);
  endtask

  initial begin
    rst = 1'b1; s_val = 1'b0; s_sop = 1'b0; s_real = '0; s_imag = '0;
    cfg_factor = '0; cfg_nvec = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_val", int'(out_val), 0);
    check("rst_eof", int'(eof), 0);
    check("rst_err_abort", int'(err_abort), 0);
    check("rst_err_drop", int'(err_drop), 0);
    check("rst_lane0", int'(dout_real[0]), 0);
    check("rst_lane4_im", int'(dout_imag[4]), 0);
    check("rst_numrtr", int'(twdl_numrtr_1), 0);
    check("rst_demontr", int'(twdl_demontr), 0);
    check("rst_factor", int'(factor), 0);
    rst = 1'b0;

    // Factor 5, M = 4, continuous input
    cfg_factor = 3'd5; cfg_nvec = 12'd4;
    for (int s = 1; s <= 20; s++) begin
      drive(1'b1, s == 1, s, s % 5 == 0);
      if (s % 5 == 0) chk_vec(s - 4, 5, s / 5 - 1, 20, s == 20);
    end
    drive(1'b0, 1'b0, 0, 1'b0);
    chk_quiet(20, 5);

    // Factor 3, M = 2: unused lanes must be zero
    cfg_factor = 3'd3; cfg_nvec = 12'd2;
    for (int s = 1; s <= 6; s++) begin
      drive(1'b1, s == 1, s, s % 3 == 0);
      if (s % 3 == 0) chk_vec(s - 2, 3, s / 3 - 1, 6, s == 6);
    end
    drive(1'b0, 1'b0, 0, 1'b0);

    // Factor 2, M = 3, s_val toggling
    cfg_factor = 3'd2; cfg_nvec = 12'd3;
    for (int s = 1; s <= 6; s++) begin
      drive(1'b1, s == 1, s, s % 2 == 0);
      if (s % 2 == 0) chk_vec(s - 1, 2, s / 2 - 1, 6, s == 6);
      drive(1'b0, 1'b0, 0, 1'b0);
    end

    // Abort: factor 4, M = 2, s_sop again on the 3rd sample
    check("pre_abort_flag", int'(err_abort), 0);
    cfg_factor = 3'd4; cfg_nvec = 12'd2;
    drive(1'b1, 1'b1, 1, 1'b0);
    drive(1'b1, 1'b0, 2, 1'b0);
    drive(1'b1, 1'b1, 3, 1'b0);
    check("abort_flag", int'(err_abort), 1);
    for (int s = 4; s <= 10; s++) begin
      drive(1'b1, 1'b0, s, s == 6 || s == 10);
      if (s == 6)  chk_vec(3, 4, 0, 8, 1'b0);
      if (s == 10) chk_vec(7, 4, 1, 8, 1'b1);
    end
    drive(1'b0, 1'b0, 0, 1'b0);
    check("pre_drop_flag", int'(err_drop), 0);

    // Drop in IDLE, then back-to-back frames
    drive(1'b1, 1'b0, 99, 1'b0);
    check("drop_flag", int'(err_drop), 1);
    drive(1'b0, 1'b0, 0, 1'b0);
    cfg_factor = 3'd2; cfg_nvec = 12'd1;
    drive(1'b1, 1'b1, 1, 1'b0);
    drive(1'b1, 1'b0, 2, 1'b1);
    chk_vec(1, 2, 0, 2, 1'b1);
    cfg_factor = 3'd3; cfg_nvec = 12'd1;
    drive(1'b1, 1'b1, 3, 1'b0);
    drive(1'b1, 1'b0, 4, 1'b0);
    drive(1'b1, 1'b0, 5, 1'b1);
    chk_vec(3, 3, 0, 3, 1'b1);
    drive(1'b0, 1'b0, 0, 1'b0);
    check("abort_sticky", int'(err_abort), 1);

    // Reset mid-frame after 2 of 5 lanes
    cfg_factor = 3'd5; cfg_nvec = 12'd1;
    drive(1'b1, 1'b1, 1, 1'b0);
    drive(1'b1, 1'b0, 2, 1'b0);
    rst = 1'b1; s_val = 1'b0; s_sop = 1'b0;
    @(posedge clk); #1;
    check("mrst_out_val", int'(out_val), 0);
    check("mrst_err_abort", int'(err_abort), 0);
    check("mrst_err_drop", int'(err_drop), 0);
    check("mrst_factor", int'(factor), 0);
    check("mrst_demontr", int'(twdl_demontr), 0);
    check("mrst_lane0", int'(dout_real[0]), 0);
    rst = 1'b0;
    repeat (3) drive(1'b0, 1'b0, 0, 1'b0);
    cfg_factor = 3'd5; cfg_nvec = 12'd2;
    for (int s = 1; s <= 5; s++) drive(1'b1, s == 1, s, s == 5);
    chk_vec(1, 5, 0, 10, 1'b0);
    repeat (2) drive(1'b0, 1'b0, 0, 1'b0);
    check("final_err_drop", int'(err_drop), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
